vec_mem_sched: RTL

//  Single-port scheduler for the vector datapath: ROM A, RAM B, RAM C (C = A + B).

---
 rtl/vec_mem_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vec_mem_sched.sv
// Single-port scheduler for ROM A / RAM B / RAM C (C = A + B): post-reset sweep, user write, user increment.
// Optional build macro VEC_SCHED_RR_EN selects round-robin write/increment arbitration (default: write wins).
module vec_mem_sched #(
    parameter int AW = 10,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          inc_req,
    input  logic [AW-1:0] inc_addr,
    output logic          inc_ack,
    input  logic          sweep_req,
    output logic          busy,
    output logic          init_done,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] a_q,
    input  logic [DW-1:0] b_q,
    output logic          b_we,
    output logic [DW-1:0] b_d,
    output logic          c_we,
    output logic [DW:0]   c_d
);

    // state      | meaning
    // S_IDLE     | bus shows rd_addr, arbitration open
    // S_SWEEP_LD | sweep: read A/B at ptr
    // S_SWEEP_WR | sweep: write C[ptr] = A + B, advance ptr
    // S_OP_LD    | user op: read A/B at latched address
    // S_OP_WR    | user op: commit B and C, pulse ack
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SWEEP_LD = 3'd1;
    localparam logic [2:0] S_SWEEP_WR = 3'd2;
    localparam logic [2:0] S_OP_LD    = 3'd3;
    localparam logic [2:0] S_OP_WR    = 3'd4;

    localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] B_ONE    = {{(DW-1){1'b0}}, 1'b1};

    logic [2:0]    state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] op_data;
    logic          op_inc;
    logic [DW-1:0] a_r;
    logic [DW-1:0] b_r;
    logic          init_done_r;
    logic          grant_wr;
    logic          grant_inc;
    logic [DW-1:0] b_new;

`ifdef VEC_SCHED_RR_EN
    // Set after a write grant so that a tied increment wins next time.
    logic pri_inc;

    always_comb begin
        grant_wr  = 1'b0;
        grant_inc = 1'b0;
        if (wr_req && inc_req) begin
            grant_inc = pri_inc;
            grant_wr  = !pri_inc;
        end else begin
            grant_wr  = wr_req;
            grant_inc = inc_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pri_inc <= 1'b0;
        end else if (state == S_IDLE && !sweep_req) begin
            if (grant_wr)
                pri_inc <= 1'b1;
            else if (grant_inc)
                pri_inc <= 1'b0;
        end
    end
`else
    always_comb begin
        grant_wr  = wr_req;
        grant_inc = inc_req && !wr_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_SWEEP_LD;
            ptr         <= '0;
            init_done_r <= 1'b0;
            op_addr     <= '0;
            op_data     <= '0;
            op_inc      <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sweep_req) begin
                        ptr   <= '0;
                        state <= S_SWEEP_LD;
                    end else if (grant_wr) begin
                        op_addr <= wr_addr;
                        op_data <= wr_data;
                        op_inc  <= 1'b0;
                        state   <= S_OP_LD;
                    end else if (grant_inc) begin
                        op_addr <= inc_addr;
                        op_inc  <= 1'b1;
                        state   <= S_OP_LD;
                    end
                end
                S_SWEEP_LD: begin
                    a_r   <= a_q;
                    b_r   <= b_q;
                    state <= S_SWEEP_WR;
                end
                S_SWEEP_WR: begin
                    if (ptr == PTR_LAST) begin
                        init_done_r <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        ptr   <= ptr + PTR_ONE;
                        state <= S_SWEEP_LD;
                    end
                end
                S_OP_LD: begin
                    a_r   <= a_q;
                    b_r   <= b_q;
                    state <= S_OP_WR;
                end
                S_OP_WR: state <= S_IDLE;
                default: state <= S_SWEEP_LD;
            endcase
        end
    end

    // Increment wraps inside B; C sees the wrapped value.
    assign b_new = op_inc ? (b_r + B_ONE) : op_data;

    always_comb begin
        mem_addr = rd_addr;
        b_we     = 1'b0;
        c_we     = 1'b0;
        b_d      = '0;
        c_d      = '0;
        wr_ack   = 1'b0;
        inc_ack  = 1'b0;
        case (state)
            S_SWEEP_LD: mem_addr = ptr;
            S_SWEEP_WR: begin
                mem_addr = ptr;
                c_we     = 1'b1;
                c_d      = {1'b0, a_r} + {1'b0, b_r};
            end
            S_OP_LD: mem_addr = op_addr;
            S_OP_WR: begin
                mem_addr = op_addr;
                b_we     = 1'b1;
                c_we     = 1'b1;
                b_d      = b_new;
                c_d      = {1'b0, a_r} + {1'b0, b_new};
                wr_ack   = !op_inc;
                inc_ack  = op_inc;
            end
            default: mem_addr = rd_addr;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign init_done = init_done_r;

endmodule
